// File: rtl/clock_set_pkg.sv
// clock_set_pkg
//   Shared definitions for the clock-adjust front end and the display drivers:
//   the mode/state encoding, the per-field index constants and small helpers
//   that map a mode onto the field it adjusts.
package clock_set_pkg;

  typedef enum logic [2:0] {
    MODE_RUN    = 3'd0,
    MODE_SET_S  = 3'd1,
    MODE_SET_MI = 3'd2,
    MODE_SET_H  = 3'd3,
    MODE_SET_D  = 3'd4
  } mode_e;

  localparam int unsigned NUM_FIELDS = 4;
  localparam int unsigned FIELD_S    = 0;
  localparam int unsigned FIELD_MI   = 1;
  localparam int unsigned FIELD_H    = 2;
  localparam int unsigned FIELD_D    = 3;

  // One-hot mask of the field adjusted in mode m; all zero in RUN or for
  // an illegal encoding.
  function automatic logic [NUM_FIELDS-1:0] field_onehot(input mode_e m);
    logic [NUM_FIELDS-1:0] oh;
    oh = '0;
    case (m)
      MODE_SET_S:  oh[FIELD_S]  = 1'b1;
      MODE_SET_MI: oh[FIELD_MI] = 1'b1;
      MODE_SET_H:  oh[FIELD_H]  = 1'b1;
      MODE_SET_D:  oh[FIELD_D]  = 1'b1;
      default:     oh = '0;
    endcase
    return oh;
  endfunction

  // Successor in the RUN -> S -> MI -> H -> D -> RUN ring. Illegal encodings
  // fall back to RUN.
  function automatic mode_e next_mode(input mode_e m);
    mode_e n;
    case (m)
      MODE_RUN:    n = MODE_SET_S;
      MODE_SET_S:  n = MODE_SET_MI;
      MODE_SET_MI: n = MODE_SET_H;
      MODE_SET_H:  n = MODE_SET_D;
      default:     n = MODE_RUN;
    endcase
    return n;
  endfunction

  function automatic logic mode_is_legal(input mode_e m);
    return (m <= MODE_SET_D);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce
//   Conditions one raw push-button: 2-FF synchronizer, then a debouncer that
//   accepts a new level only after DEBOUNCE_CYCLES consecutive identical
//   synchronized samples. A debounced 0->1 transition gives a one-cycle press.
//   Raw edge to press: DEBOUNCE_CYCLES + 2 cycles.
// Ports:
//   clk     - clock
//   rst_n   - asynchronous active-low reset
//   btn_raw - raw asynchronous button, active high
//   level   - debounced level
//   press   - one-cycle pulse on a debounced rising edge (same cycle level rises)
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The counter holds the number of consecutive samples that disagree with
  // the accepted level; any agreeing sample restarts it, so it never wraps.
  always_comb begin
    level_d = level_q;
    press_d = 1'b0;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        level_d = sync2_q;
        press_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/time_set_ctrl.sv
// time_set_ctrl
//   User-adjust front end for the clock datapath. Conditions the mode/up/down
//   buttons, walks RUN -> SET_S -> SET_MI -> SET_H -> SET_D -> RUN on mode
//   presses, and produces per-field counter enables, single-cycle
//   increase/decrease pulses (with auto-repeat) and the display blink mask.
// Ports:
//   clk, rst                       - clock, asynchronous active-low reset
//   btn_mode, btn_up, btn_down     - raw active-high buttons
//   enable_pulse_1s                - 1 s tick generator enable (RUN only)
//   enable_cnt_{s,mi,h,d}          - per-counter enables
//   increase_{s,mi,h,d}            - one-cycle increment pulses
//   decrease_{s,mi,h,d}            - one-cycle decrement pulses
//   enable_display[5:0]            - blink mask; [3:0] = s,mi,h,d, [5:4] = 1
//   mode[2:0]                      - current state encoding
module time_set_ctrl
  import clock_set_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000,
  parameter int unsigned BLINK_HALF      = 12500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic       enable_pulse_1s,
  output logic       enable_cnt_s,
  output logic       enable_cnt_mi,
  output logic       enable_cnt_h,
  output logic       enable_cnt_d,
  output logic       increase_s,
  output logic       increase_mi,
  output logic       increase_h,
  output logic       increase_d,
  output logic       decrease_s,
  output logic       decrease_mi,
  output logic       decrease_h,
  output logic       decrease_d,
  output logic [5:0] enable_display,
  output logic [2:0] mode
);

  localparam int unsigned HW = $clog2(REPEAT_DELAY + 1);
  localparam int unsigned BW = $clog2(BLINK_HALF + 1);
  // After a repeat pulse the hold counter is reloaded so that it reaches
  // REPEAT_DELAY again REPEAT_PERIOD cycles later.
  localparam int unsigned REPEAT_RELOAD =
      (REPEAT_PERIOD >= REPEAT_DELAY) ? 1 : (REPEAT_DELAY - REPEAT_PERIOD + 1);

  localparam int unsigned BTN_MODE = 0;
  localparam int unsigned BTN_UP   = 1;
  localparam int unsigned BTN_DOWN = 2;

  // Reset asserts asynchronously and releases on a clock edge.
  logic rst_meta_q, rst_sync_q, rst_n_int;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rst_meta_q <= 1'b0;
      rst_sync_q <= 1'b0;
    end else begin
      rst_meta_q <= 1'b1;
      rst_sync_q <= rst_meta_q;
    end
  end

  assign rst_n_int = rst_sync_q;

  logic [2:0] btn_raw, btn_lvl, btn_press;
  assign btn_raw = {btn_down, btn_up, btn_mode};

  for (genvar gi = 0; gi < 3; gi++) begin : g_btn
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
      .clk     (clk),
      .rst_n   (rst_n_int),
      .btn_raw (btn_raw[gi]),
      .level   (btn_lvl[gi]),
      .press   (btn_press[gi])
    );
  end

  // Only the press event of the mode button matters, not its level.
  logic unused_mode_lvl;
  assign unused_mode_lvl = btn_lvl[BTN_MODE];

  logic mode_press, up_press, down_press, up_lvl, down_lvl;
  assign mode_press = btn_press[BTN_MODE];
  assign up_press   = btn_press[BTN_UP];
  assign down_press = btn_press[BTN_DOWN];
  assign up_lvl     = btn_lvl[BTN_UP];
  assign down_lvl   = btn_lvl[BTN_DOWN];

  mode_e                 state_q, state_d;
  logic [HW-1:0]         hold_q, hold_d;
  logic [BW-1:0]         blink_cnt_q, blink_cnt_d;
  logic                  blink_q, blink_d;
  logic [NUM_FIELDS-1:0] inc_q, inc_d, dec_q, dec_d;
  logic [NUM_FIELDS-1:0] field_sel;
  logic                  set_mode;
  logic                  one_high;
  logic                  fire;

  assign field_sel = field_onehot(state_q);
  assign set_mode  = |field_sel;
  assign one_high  = up_lvl ^ down_lvl;

  // Next state
  always_comb begin
    state_d = state_q;
    if (mode_press || !mode_is_legal(state_q)) begin
      state_d = next_mode(state_q);
    end
  end

  // Pulse generation and hold/repeat counter. hold_q == 0 means "not armed":
  // only a press event accepted while exactly one of up/down is high arms it,
  // so a press discarded by a conflict never starts auto-repeat.
  always_comb begin
    hold_d = '0;
    fire   = 1'b0;
    inc_d  = '0;
    dec_d  = '0;
    if (set_mode && !mode_press && one_high) begin
      if (up_press || down_press) begin
        fire   = 1'b1;
        hold_d = HW'(1);
      end else if (hold_q != '0) begin
        if (hold_q == HW'(REPEAT_DELAY)) begin
          fire   = 1'b1;
          hold_d = HW'(REPEAT_RELOAD);
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
    end
    if (fire) begin
      if (up_lvl) inc_d = field_sel;
      else        dec_d = field_sel;
    end
  end

  // Blink: any state change restarts the phase at "visible"; in RUN the
  // counter idles at 0.
  always_comb begin
    blink_cnt_d = '0;
    blink_d     = 1'b1;
    if (set_mode && (state_d == state_q)) begin
      if (blink_cnt_q == BW'(BLINK_HALF - 1)) begin
        blink_cnt_d = '0;
        blink_d     = ~blink_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
        blink_d     = blink_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state_q     <= MODE_RUN;
      hold_q      <= '0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b1;
      inc_q       <= '0;
      dec_q       <= '0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
      inc_q       <= inc_d;
      dec_q       <= dec_d;
    end
  end

  // Output decode
  logic [NUM_FIELDS-1:0] en_cnt;
  logic [NUM_FIELDS-1:0] disp_fields;

  assign en_cnt      = set_mode ? field_sel : '1;
  assign disp_fields = set_mode ? (~field_sel | {NUM_FIELDS{blink_q}}) : '1;

  assign enable_pulse_1s = ~set_mode;
  assign enable_cnt_s    = en_cnt[FIELD_S];
  assign enable_cnt_mi   = en_cnt[FIELD_MI];
  assign enable_cnt_h    = en_cnt[FIELD_H];
  assign enable_cnt_d    = en_cnt[FIELD_D];
  assign increase_s      = inc_q[FIELD_S];
  assign increase_mi     = inc_q[FIELD_MI];
  assign increase_h      = inc_q[FIELD_H];
  assign increase_d      = inc_q[FIELD_D];
  assign decrease_s      = dec_q[FIELD_S];
  assign decrease_mi     = dec_q[FIELD_MI];
  assign decrease_h      = dec_q[FIELD_H];
  assign decrease_d      = dec_q[FIELD_D];
  assign enable_display  = {2'b11, disp_fields};
  assign mode            = state_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
module tb_time_set_ctrl;

  logic       clk;
  logic       rst;
  logic       btn_mode, btn_up, btn_down;
  logic       enable_pulse_1s;
  logic       enable_cnt_s, enable_cnt_mi, enable_cnt_h, enable_cnt_d;
  logic       increase_s, increase_mi, increase_h, increase_d;
  logic       decrease_s, decrease_mi, decrease_h, decrease_d;
  logic [5:0] enable_display;
  logic [2:0] mode;

  time_set_ctrl #(
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (20),
    .REPEAT_PERIOD   (5),
    .BLINK_HALF      (8)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .btn_mode        (btn_mode),
    .btn_up          (btn_up),
    .btn_down        (btn_down),
    .enable_pulse_1s (enable_pulse_1s),
    .enable_cnt_s    (enable_cnt_s),
    .enable_cnt_mi   (enable_cnt_mi),
    .enable_cnt_h    (enable_cnt_h),
    .enable_cnt_d    (enable_cnt_d),
    .increase_s      (increase_s),
    .increase_mi     (increase_mi),
    .increase_h      (increase_h),
    .increase_d      (increase_d),
    .decrease_s      (decrease_s),
    .decrease_mi     (decrease_mi),
    .decrease_h      (decrease_h),
    .decrease_d      (decrease_d),
    .enable_display  (enable_display),
    .mode            (mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] inc_vec, dec_vec, en_vec;
  assign inc_vec = {increase_d, increase_h, increase_mi, increase_s};
  assign dec_vec = {decrease_d, decrease_h, decrease_mi, decrease_s};
  assign en_vec  = {enable_cnt_d, enable_cnt_h, enable_cnt_mi, enable_cnt_s};

  int total = 0;
  int bad = 0;
  int multi_hot = 0;

  // Results of the last button window
  int         pk[$];
  int         mode_k;
  logic [3:0] seen_inc, seen_dec;

  typedef struct {
    logic [2:0] btns;      // {down, up, mode}
    int         exp_mode;
    int         exp_p1s;
    int         exp_en;
    int         exp_inc;
    int         exp_dec;
    int         exp_first; // cycle of first visible effect, -1 = none
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if ($countones({inc_vec, dec_vec}) > 1) multi_hot++;
  endtask

  // Drive buttons b for 'high' cycles, then release; observe 'win' cycles.
  task automatic run_btn(input logic [2:0] b, input int high, input int win);
    logic [2:0] m0;
    m0 = mode;
    pk.delete();
    mode_k   = -1;
    seen_inc = '0;
    seen_dec = '0;
    {btn_down, btn_up, btn_mode} = b;
    for (int k = 1; k <= win; k++) begin
      if (k == high + 1) {btn_down, btn_up, btn_mode} = 3'b000;
      tick();
      if ((|inc_vec) || (|dec_vec)) pk.push_back(k);
      if (mode_k < 0 && mode != m0) mode_k = k;
      seen_inc |= inc_vec;
      seen_dec |= dec_vec;
    end
  endtask

  initial begin
    int         first;
    int         bounce_p;
    int         blink_bad, oth_bad;
    logic       exp_b;
    logic [2:0] mode6, mode7;
    logic [5:0] disp7;

    // {btns, mode, p1s, en, inc, dec, first}
    vecs[0]  = '{3'b010, 0, 1, 15, 0, 0, -1};
    vecs[1]  = '{3'b001, 1, 0,  1, 0, 0,  7};
    vecs[2]  = '{3'b010, 1, 0,  1, 1, 0,  7};
    vecs[3]  = '{3'b100, 1, 0,  1, 0, 1,  7};
    vecs[4]  = '{3'b001, 2, 0,  2, 0, 0,  7};
    vecs[5]  = '{3'b010, 2, 0,  2, 2, 0,  7};
    vecs[6]  = '{3'b001, 3, 0,  4, 0, 0,  7};
    vecs[7]  = '{3'b100, 3, 0,  4, 0, 4,  7};
    vecs[8]  = '{3'b001, 4, 0,  8, 0, 0,  7};
    vecs[9]  = '{3'b010, 4, 0,  8, 8, 0,  7};
    vecs[10] = '{3'b100, 4, 0,  8, 0, 8,  7};
    vecs[11] = '{3'b001, 0, 1, 15, 0, 0,  7};

    btn_mode = 1'b0;
    btn_up   = 1'b0;
    btn_down = 1'b0;
    rst      = 1'b1;
    #2 rst = 1'b0;
    repeat (3) tick();
    check("reset_mode", int'(mode), 0);
    check("reset_p1s", int'(enable_pulse_1s), 1);
    check("reset_en", int'(en_vec), 15);
    check("reset_pulses", int'({inc_vec, dec_vec}), 0);
    check("reset_disp", int'(enable_display), 63);
    rst = 1'b1;
    repeat (5) tick();

    // Table: clean presses through the whole mode ring
    for (int i = 0; i < 12; i++) begin
      run_btn(vecs[i].btns, 10, 22);
      first = (pk.size() > 0) ? pk[0] : -1;
      if (mode_k > 0 && (first < 0 || mode_k < first)) first = mode_k;
      $display("vec %0d btns=%b mode=%0d en=%b inc=%b dec=%b pulses=%0d first=%0d",
               i, vecs[i].btns, mode, en_vec, seen_inc, seen_dec, pk.size(), first);
      check($sformatf("vec%0d_mode", i), int'(mode), vecs[i].exp_mode);
      check($sformatf("vec%0d_p1s", i), int'(enable_pulse_1s), vecs[i].exp_p1s);
      check($sformatf("vec%0d_en", i), int'(en_vec), vecs[i].exp_en);
      check($sformatf("vec%0d_inc", i), int'(seen_inc), vecs[i].exp_inc);
      check($sformatf("vec%0d_dec", i), int'(seen_dec), vecs[i].exp_dec);
      check($sformatf("vec%0d_npulse", i), pk.size(),
            ((vecs[i].exp_inc | vecs[i].exp_dec) != 0) ? 1 : 0);
      check($sformatf("vec%0d_latency", i), first, vecs[i].exp_first);
      if (vecs[i].exp_mode == 0)
        check($sformatf("vec%0d_disp", i), int'(enable_display), 63);
    end

    // Bounce in SET_S
    run_btn(3'b001, 10, 22);
    check("bounce_enter_mode", int'(mode), 1);
    bounce_p = 0;
    for (int i = 0; i < 20; i++) begin
      btn_up = ((i % 4) < 2);
      tick();
      if ((|inc_vec) || (|dec_vec)) bounce_p++;
    end
    run_btn(3'b010, 10, 24);
    $display("bounce: pulses during bounce=%0d after=%0d first=%0d", bounce_p, pk.size(),
             (pk.size() > 0) ? pk[0] : -1);
    check("bounce_glitch_pulses", bounce_p, 0);
    check("bounce_npulse", pk.size(), 1);
    check("bounce_latency", (pk.size() > 0) ? pk[0] : -1, 7);
    check("bounce_inc_s", int'(seen_inc), 1);

    // Auto-repeat in SET_H: debounced down high for 40 cycles after press event
    run_btn(3'b001, 10, 22);
    run_btn(3'b001, 10, 22);
    check("repeat_enter_mode", int'(mode), 3);
    run_btn(3'b100, 40, 60);
    $display("repeat: pulses=%0d dec=%b inc=%b", pk.size(), seen_dec, seen_inc);
    check("repeat_npulse", pk.size(), 5);
    check("repeat_dec_h", int'(seen_dec), 4);
    check("repeat_no_inc", int'(seen_inc), 0);
    for (int i = 0; i < 5; i++) begin
      int exp_off[5] = '{1, 21, 26, 31, 36};
      check($sformatf("repeat_off%0d", i), (pk.size() > i) ? pk[i] - 6 : -1, exp_off[i]);
    end

    // Blink in SET_D
    blink_bad = 0;
    oth_bad   = 0;
    btn_mode  = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      if (k == 11) btn_mode = 1'b0;
      tick();
      if (k >= 7) begin
        exp_b = ((((k - 7) / 8) % 2) == 0);
        if (enable_display[3] !== exp_b) blink_bad++;
        if ({enable_display[5:4], enable_display[2:0]} !== 5'h1F) oth_bad++;
      end
    end
    $display("blink: mode=%0d bad_bit3=%0d bad_other=%0d", mode, blink_bad, oth_bad);
    check("blink_mode", int'(mode), 4);
    check("blink_bit3", blink_bad, 0);
    check("blink_others", oth_bad, 0);

    // Return to RUN
    mode6    = '0;
    mode7    = '0;
    disp7    = '0;
    btn_mode = 1'b1;
    for (int k = 1; k <= 22; k++) begin
      if (k == 11) btn_mode = 1'b0;
      tick();
      if (k == 6) mode6 = mode;
      if (k == 7) begin
        mode7 = mode;
        disp7 = enable_display;
      end
    end
    $display("return: mode6=%0d mode7=%0d disp7=%b", mode6, mode7, disp7);
    check("return_mode_before", int'(mode6), 4);
    check("return_mode_after", int'(mode7), 0);
    check("return_disp", int'(disp7), 63);

    // Conflicts in SET_MI
    run_btn(3'b001, 10, 22);
    run_btn(3'b001, 10, 22);
    check("conflict_enter_mode", int'(mode), 2);
    run_btn(3'b110, 30, 44);
    $display("conflict both: pulses=%0d", pk.size());
    check("conflict_both_pulses", pk.size(), 0);

    // Up first, down joins later: only the original up pulse
    pk.delete();
    seen_inc = '0;
    btn_up   = 1'b1;
    for (int k = 1; k <= 54; k++) begin
      if (k == 11) btn_down = 1'b1;
      if (k == 41) begin
        btn_up   = 1'b0;
        btn_down = 1'b0;
      end
      tick();
      if ((|inc_vec) || (|dec_vec)) pk.push_back(k);
      seen_inc |= inc_vec;
    end
    $display("conflict late down: pulses=%0d inc=%b", pk.size(), seen_inc);
    check("conflict_late_npulse", pk.size(), 1);
    check("conflict_late_first", (pk.size() > 0) ? pk[0] : -1, 7);
    check("conflict_late_inc_mi", int'(seen_inc), 2);

    run_btn(3'b011, 30, 44);
    $display("conflict mode+up: mode=%0d mode_k=%0d pulses=%0d", mode, mode_k, pk.size());
    check("conflict_modeup_mode", int'(mode), 3);
    check("conflict_modeup_latency", mode_k, 7);
    check("conflict_modeup_pulses", pk.size(), 0);

    // Reset mid-hold and mid-blink (SET_H)
    btn_up = 1'b1;
    repeat (12) tick();
    #3 rst = 1'b0;
    #1;
    $display("midrun reset: mode=%0d p1s=%b en=%b disp=%b", mode, enable_pulse_1s, en_vec,
             enable_display);
    check("midreset_mode", int'(mode), 0);
    check("midreset_p1s", int'(enable_pulse_1s), 1);
    check("midreset_en", int'(en_vec), 15);
    check("midreset_pulses", int'({inc_vec, dec_vec}), 0);
    check("midreset_disp", int'(enable_display), 63);
    btn_up = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    pk.delete();
    mode_k = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if ((|inc_vec) || (|dec_vec)) pk.push_back(k);
      if (mode_k < 0 && mode != 3'd0) mode_k = k;
    end
    $display("post reset idle: pulses=%0d mode=%0d", pk.size(), mode);
    check("postreset_pulses", pk.size(), 0);
    check("postreset_mode_change", mode_k, -1);

    check("onehot_pulses", multi_hot, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/time_set_ctrl.md
# time_set_ctrl

User-adjust front end for the clock datapath: it turns three raw push-buttons into the per-field `enable_cnt_*`, `increase_*` and `decrease_*` controls that the second/minute/hour/day counters consume. It also gates the 1 s tick generator and produces the `enable_display` blink mask for the 7-segment drivers. It sits between the board buttons and the counter chain, on the input side of the counters (the display drivers are on the output side).

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 500000 — consecutive stable samples required to accept a button level (10 ms at 50 MHz).
- `REPEAT_DELAY`, 25000000 — hold time before auto-repeat starts.
- `REPEAT_PERIOD`, 5000000 — auto-repeat pulse spacing.
- `BLINK_HALF`, 12500000 — half-period of the display blink.

Ports:
- `clk`, in, 1 — single clock; every flop is on its rising edge.
- `rst`, in, 1 — asynchronous, active-low reset.
- `btn_mode`, `btn_up`, `btn_down`, in, 1 each — raw, asynchronous, active-high buttons.
- `enable_pulse_1s`, out, 1 — enables the 1 s tick generator.
- `enable_cnt_s`, `enable_cnt_mi`, `enable_cnt_h`, `enable_cnt_d`, out, 1 each — per-counter enables.
- `increase_s`, `increase_mi`, `increase_h`, `increase_d`, out, 1 each — single-cycle increment pulses.
- `decrease_s`, `decrease_mi`, `decrease_h`, `decrease_d`, out, 1 each — single-cycle decrement pulses.
- `enable_display`, out, 6 — display enable mask. Bit 0 = s, bit 1 = mi, bit 2 = h, bit 3 = d, bits 5:4 = reserved and always 1.
- `mode`, out, 3 — current state encoding, for debug and LEDs.

## Operation
- **Input conditioning.** Each button passes through a 2-FF synchronizer, then a debouncer.
  - The debounced level changes only after `DEBOUNCE_CYCLES` consecutive identical synchronized samples.
  - A debounced 0→1 transition produces one press event.
- **State machine.** States: RUN (0) → SET_S (1) → SET_MI (2) → SET_H (3) → SET_D (4) → RUN.
  - The FSM advances one state per mode press event.
  - Encodings 5–7 are illegal and return to RUN on the next cycle.
- **Outputs in RUN:**
  - `enable_pulse_1s` = 1.
  - All `enable_cnt_*` = 1.
  - No `increase_*`/`decrease_*` pulses.
  - `enable_display` = 6'b111111.
- **Outputs in SET_x:**
  - `enable_pulse_1s` = 0.
  - Only `enable_cnt_x` = 1; the other enables are 0.
  - An up press event pulses `increase_x`; a down press event pulses `decrease_x`.
  - `enable_display` bit x toggles every `BLINK_HALF` cycles; all other bits are 1.
- **Auto-repeat** (SET states only).
  - While up or down remains debounced-high after its press event, a hold counter runs.
  - At `REPEAT_DELAY` cycles the block emits one further pulse, then one pulse every `REPEAT_PERIOD` cycles until release.
- **Boundary rules:**
  - Up and down both debounced-high: no pulses, and the hold counter is cleared. A button's press event that arrives while the other button is high is discarded.
  - A mode press event in the same cycle as an up/down press event: the mode event wins and the up/down event is discarded. A mode press event also clears the hold counter.
  - Entering any state: the blink phase resets to visible (bit = 1) and the blink counter resets to 0.
  - At most one of the 8 `increase_*`/`decrease_*` outputs is high in any cycle.
  - Holding mode does not auto-repeat.

## Timing
- Reset values:
  - FSM = RUN, `mode` = 0.
  - `enable_pulse_1s` = 1.
  - `enable_cnt_*` = 1.
  - All `increase_*`/`decrease_*` = 0.
  - `enable_display` = 6'b111111.
  - All counters = 0; debounced levels = 0.
- Reset is asserted asynchronously and released synchronously through the same clock. Asserting reset mid-hold or mid-blink aborts that activity immediately.
- Raw edge to press event: `DEBOUNCE_CYCLES` + 2 cycles. Press event to output pulse: 1 cycle, registered. Total: `DEBOUNCE_CYCLES` + 3.
- Mode press event to new `mode` / `enable_*` values: 1 cycle, registered.
- Each increase/decrease pulse is exactly one `clk` cycle wide.
- Glitches shorter than `DEBOUNCE_CYCLES` samples produce no event.
- Counter widths are `$clog2(param+1)`. Every counter saturates or reloads and never wraps silently.

## Structure
- Package `clock_set_pkg`:
  - Mode state encoding constants (RUN, SET_S, SET_MI, SET_H, SET_D).
  - Field index constants (S=0, MI=1, H=2, D=3).
  - Shared by this block and the display drivers.
- Sub-module `btn_debounce`:
  - Contains the synchronizer, stable counter, debounced level and rising-edge pulse.
  - Parameter `DEBOUNCE_CYCLES`.
  - Instantiated three times.
- Top level holds the FSM, the hold/repeat counter, the blink counter and the output decode.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES`=4, `REPEAT_DELAY`=20, `REPEAT_PERIOD`=5, `BLINK_HALF`=8.
- **Reset:** drive `rst`=0 mid-run → all outputs at their reset values in the same cycle and `mode`=0. After release, no pulses appear without button activity.
- **Bounce:** `btn_up` toggles every 2 cycles for 20 cycles, then holds high, in SET_S → exactly one `increase_s` pulse, 7 cycles after the final rising edge.
- **Mode walk:** five clean mode presses → `mode` goes 1,2,3,4,0. `enable_pulse_1s`=0 in states 1–4. `enable_cnt_*` is one-hot on the selected field.
- **Auto-repeat:** in SET_H, hold `btn_down` for 40 cycles after its press event → `decrease_h` pulses at offsets 1, 21, 26, 31 and 36, and nothing else.
- **Conflict:** in SET_MI, up and down high together → zero pulses. A mode press event coinciding with an up press event → `mode` advances and no `increase_mi` pulse.
- **Blink:** in SET_D → `enable_display[3]` toggles every 8 cycles starting at 1, while the other bits hold 1. Returning to RUN → 6'b111111 on the next cycle.
